// File: rtl/alu_pkg.sv
// Shared definitions for the simple_alu slice: widths, opcodes, FSM states and COMP codes.
package alu_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned CNT_W          = 4;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD  = 2'b00;
  localparam op_t OP_SUB  = 2'b01;
  localparam op_t OP_PAR  = 2'b10;
  localparam op_t OP_COMP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_B,
    ST_EXEC,
    ST_DONE
  } state_t;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_GT = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: ADD/SUB/PAR/COMP on two unsigned operands.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  op_t                   op,
  output logic [DATA_WIDTH-1:0] next_result,
  output logic                  next_overflow
);

  logic [DATA_WIDTH:0] w_sum;
  logic [1:0]          w_cmp;

  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_cmp = (a == b) ? CMP_EQ : ((a > b) ? CMP_GT : CMP_LT);

  always_comb begin
    next_result   = '0;
    next_overflow = 1'b0;
    case (op)
      OP_ADD: {next_overflow, next_result} = w_sum;
      OP_SUB: begin
        next_result   = a - b;
        next_overflow = (a < b);
      end
      OP_PAR:  next_result = {{(DATA_WIDTH-1){1'b0}}, ^{a, b}};
      OP_COMP: next_result = DATA_WIDTH'(w_cmp);
      default: next_result = '0;
    endcase
  end

endmodule

// File: rtl/simple_alu.sv
// Two-operand ALU fed by a serial opcode stream; A and B arrive A_TO_B_CYCLES edges apart
// and done is held until opcode_valid drops.
module simple_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned A_TO_B_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  opcode_valid,
  input  logic                  opcode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  done,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] result
);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_overflow;
  op_t                   r_op;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_b_edge;
  logic [DATA_WIDTH-1:0] w_next_result;
  logic                  w_next_overflow;

  assign w_b_edge = (r_cnt == CNT_W'(A_TO_B_CYCLES));

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .a            (r_a),
    .b            (r_b),
    .op           (r_op),
    .next_result  (w_next_result),
    .next_overflow(w_next_overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (opcode_valid) w_next_state = ST_WAIT_B;
      ST_WAIT_B: begin
        if (!opcode_valid) w_next_state = ST_IDLE;
        else if (w_b_edge) w_next_state = ST_EXEC;
      end
      ST_EXEC:   w_next_state = opcode_valid ? ST_DONE : ST_IDLE;
      ST_DONE:   if (!opcode_valid) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // done is a pure decode of ST_DONE, so it rises with the EXEC edge and falls with the exit edge.
  always_comb begin
    done     = (r_state == ST_DONE);
    result   = r_result;
    overflow = r_overflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else if (opcode_valid) begin
      case (r_state)
        ST_IDLE: begin
          r_a     <= data;
          r_op[0] <= opcode;
          r_cnt   <= CNT_W'(1);
        end
        ST_WAIT_B: begin
          if (w_b_edge) begin
            r_b     <= data;
            r_op[1] <= opcode;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          r_result   <= w_next_result;
          r_overflow <= w_next_overflow;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_alu.sv
// Self-checking bench for simple_alu: vector table through a result scoreboard, plus
// no-valid, abort and reset-mid-operation sequences.
module tb_simple_alu;

  logic       clk;
  logic       reset;
  logic       opcode_valid;
  logic       opcode;
  logic [7:0] data;
  logic       done;
  logic       overflow;
  logic [7:0] result;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] res;
    logic       ovf;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[9];
  logic [7:0] last_res;
  logic       last_ovf;

  simple_alu #(
    .DATA_WIDTH   (8),
    .A_TO_B_CYCLES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode_valid(opcode_valid),
    .opcode      (opcode),
    .data        (data),
    .done        (done),
    .overflow    (overflow),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [7:0] res, input logic ovf);
    exp_t e;
    exp_t got;
    int   lat;
    e.res = res;
    e.ovf = ovf;
    sb.push_back(e);
    @(negedge clk);
    opcode_valid = 1'b1;
    data         = a;
    opcode       = op[0];
    @(posedge clk);
    @(negedge clk);
    data   = b;
    opcode = op[1];
    lat    = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n >= 2) begin
        data   = 8'($urandom);
        opcode = 1'($urandom);
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({name, " latency"}, lat, 3);
    got = sb.pop_front();
    last_res = got.res;
    last_ovf = got.ovf;
    if (lat != 0) begin
      chk({name, " result"}, result, got.res);
      chk({name, " overflow"}, overflow, got.ovf);
      repeat (2) @(negedge clk);
      chk({name, " done held"}, done, 1);
      chk({name, " result held"}, result, got.res);
    end
    opcode_valid = 1'b0;
    @(negedge clk);
    chk({name, " done cleared"}, done, 0);
    chk({name, " result kept"}, {overflow, result}, {got.ovf, got.res});
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk({name, " no done"}, seen, 0);
    chk({name, " result kept"}, result, last_res);
    chk({name, " overflow kept"}, overflow, last_ovf);
  endtask

  initial begin
    vecs[0] = '{"sub 00-ff", 8'h00, 8'hFF, 2'b01, 8'h01, 1'b1};
    vecs[1] = '{"sub ff-01", 8'hFF, 8'h01, 2'b01, 8'hFE, 1'b0};
    vecs[2] = '{"par aa,55", 8'hAA, 8'h55, 2'b10, 8'h00, 1'b0};
    vecs[3] = '{"par 33,5c", 8'h33, 8'h5C, 2'b10, 8'h00, 1'b0};
    vecs[4] = '{"par 01,00", 8'h01, 8'h00, 2'b10, 8'h01, 1'b0};
    vecs[5] = '{"comp 20,df", 8'h20, 8'hDF, 2'b11, 8'h02, 1'b0};
    vecs[6] = '{"comp c2,c2", 8'hC2, 8'hC2, 2'b11, 8'h00, 1'b0};
    vecs[7] = '{"comp df,20", 8'hDF, 8'h20, 2'b11, 8'h01, 1'b0};
    vecs[8] = '{"add ff+ff", 8'hFF, 8'hFF, 2'b00, 8'hFE, 1'b1};

    reset        = 1'b1;
    opcode_valid = 1'b0;
    opcode       = 1'b0;
    data         = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset done", done, 0);
    chk("reset result", result, 8'h00);
    chk("reset overflow", overflow, 0);
    reset = 1'b0;
    last_res = 8'h00;
    last_ovf = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].ovf);
    end

    // operands presented without opcode_valid must be ignored
    @(negedge clk);
    data   = 8'hAA;
    opcode = 1'b1;
    @(negedge clk);
    data = 8'h55;
    watch_no_done("no valid", 5);

    // abort in WAIT_B: valid drops before the B edge
    @(negedge clk);
    opcode_valid = 1'b1;
    data         = 8'h98;
    opcode       = 1'b0;
    @(negedge clk);
    opcode_valid = 1'b0;
    watch_no_done("abort wait_b", 6);

    // abort in EXEC: B sampled, valid drops before the execute edge
    @(negedge clk);
    opcode_valid = 1'b1;
    data         = 8'h12;
    opcode       = 1'b1;
    @(negedge clk);
    data   = 8'h34;
    opcode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    opcode_valid = 1'b0;
    watch_no_done("abort exec", 6);

    run_op("add c2+e3", 8'hC2, 8'hE3, 2'b00, 8'hA5, 1'b1);

    // reset asserted on the B-sample edge of an in-flight ADD
    @(negedge clk);
    opcode_valid = 1'b1;
    data         = 8'hFF;
    opcode       = 1'b0;
    @(negedge clk);
    data = 8'h01;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midop reset done", done, 0);
    chk("midop reset result", result, 8'h00);
    chk("midop reset overflow", overflow, 0);
    reset        = 1'b0;
    opcode_valid = 1'b0;
    last_res     = 8'h00;
    last_ovf     = 1'b0;
    watch_no_done("after reset", 3);

    run_op("add 33+5c", 8'h33, 8'h5C, 2'b00, 8'h8F, 1'b0);

    chk("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
